// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the N-to-1 memory request arbiter.
package mem_req_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Index width for n items; a single item still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Circular FIFO of port indices for granted-but-unanswered transactions.
// Registered head only: a pushed entry becomes visible on the following cycle.
module mem_id_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = idx_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: every variable gets a default before any condition so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin N-to-1 req/gnt/rvalid arbiter with grant lock under stall and
// in-order response routing through an ID queue.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned ADDRESS_SIZE    = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [ADDRESS_SIZE-1:0]              address_i     [NR_PORTS],
  input  logic [DATA_WIDTH-1:0]                data_wdata_i  [NR_PORTS],
  input  logic                                 data_req_i    [NR_PORTS],
  input  logic                                 data_we_i     [NR_PORTS],
  input  logic [DATA_WIDTH/8-1:0]              data_be_i     [NR_PORTS],
  output logic                                 data_gnt_o    [NR_PORTS],
  output logic                                 data_rvalid_o [NR_PORTS],
  output logic [DATA_WIDTH-1:0]                data_rdata_o  [NR_PORTS],
  output logic [ADDRESS_SIZE-1:0]              address_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic                                 data_req_o,
  output logic                                 data_we_o,
  output logic [DATA_WIDTH/8-1:0]              data_be_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                data_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned IW = idx_width(NR_PORTS);

  typedef logic [IW-1:0] port_idx_t;

  lock_state_e state_q, state_d;
  port_idx_t   rr_q, rr_d;
  port_idx_t   lock_idx_q, lock_idx_d;
  port_idx_t   sel, head;
  logic        sel_valid, full, empty, push, pop;

  // While locked the stalled port owns the bus; otherwise scan from rr_q.
  always_comb begin
    int unsigned cand;
    port_idx_t   c;
    cand      = 0;
    c         = '0;
    sel       = lock_idx_q;
    sel_valid = 1'b0;
    if (state_q == LOCKED) begin
      sel_valid = data_req_i[lock_idx_q];
    end else begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        cand = 32'(rr_q) + i;
        if (cand >= NR_PORTS) cand = cand - NR_PORTS;
        c = port_idx_t'(cand);
        if (!sel_valid && data_req_i[c]) begin
          sel       = c;
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    address_o    = '0;
    data_wdata_o = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    if (sel_valid) begin
      address_o    = address_i[sel];
      data_wdata_o = data_wdata_i[sel];
      data_we_o    = data_we_i[sel];
      data_be_o    = data_be_i[sel];
    end
  end

  // Full gates the request even if a pop lands in the same cycle, keeping rvalid off the req path.
  assign data_req_o = sel_valid && !full;
  assign push       = data_req_o && data_gnt_i;
  assign pop        = data_rvalid_i;

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      data_gnt_o[p]    = push && (sel == port_idx_t'(p));
      data_rvalid_o[p] = data_rvalid_i && !empty && (head == port_idx_t'(p));
      data_rdata_o[p]  = data_rdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    case (state_q)
      IDLE: begin
        if (data_req_o && !data_gnt_i) begin
          state_d    = LOCKED;
          lock_idx_d = sel;
        end
      end
      LOCKED: begin
        if (data_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push) rr_d = (sel == port_idx_t'(NR_PORTS - 1)) ? '0 : sel + port_idx_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  mem_id_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(state_q == LOCKED && !data_req_i[lock_idx_q]))
        else $error("locked port dropped its request before grant");
      assert (!(data_rvalid_i && empty))
        else $error("rvalid with no outstanding transaction");
    end
  end
`endif

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-to-1 arbiter for the core's generic req/gnt/rvalid memory protocol. It lets `NR_PORTS` requesters share one memory port and routes each response back to the port that issued it. Selection is round-robin, and the grant is locked while a request is stalled. A depth-bounded in-order ID queue tracks up to `MAX_OUTSTANDING` granted-but-unanswered transactions. It sits between the core's load/store/fetch clients and the shared memory or cache port.

## Interface
- `NR_PORTS`, default 3: number of requesting ports, ≥2.
- `ADDRESS_SIZE`, default 64: address width.
- `DATA_WIDTH`, default 64: data width, multiple of 8.
- `MAX_OUTSTANDING`, default 4: ID queue depth, ≥1.
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `address_i[NR_PORTS]`  in  ADDRESS_SIZE  per-port request address.
- `data_wdata_i[NR_PORTS]`  in  DATA_WIDTH  per-port write data.
- `data_req_i[NR_PORTS]`  in  1  per-port request.
- `data_we_i[NR_PORTS]`  in  1  per-port write enable.
- `data_be_i[NR_PORTS]`  in  DATA_WIDTH/8  per-port byte enable.
- `data_gnt_o[NR_PORTS]`  out  1  per-port grant.
- `data_rvalid_o[NR_PORTS]`  out  1  per-port response valid.
- `data_rdata_o[NR_PORTS]`  out  DATA_WIDTH  per-port read data.
- `address_o`, `data_wdata_o`, `data_req_o`, `data_we_o`, `data_be_o`  out  as above  shared memory-side request.
- `data_gnt_i`  in  1  memory grant.
- `data_rvalid_i`  in  1  memory response valid.
- `data_rdata_i`  in  DATA_WIDTH  memory read data.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING+1)  current queue occupancy.

## Operation
- **Protocol.**
  - A requester holds req and its attributes stable until gnt.
  - Every granted transaction, read or write, returns exactly one rvalid.
  - Responses return in grant order.
- **Arbitration.**
  - Round-robin pointer `rr_q`, reset 0.
  - Among requesting ports, select the first at or after `rr_q`, modulo `NR_PORTS`.
  - On a grant to port k, `rr_q` becomes (k+1) mod `NR_PORTS`.
- **Lock state machine.**
  - States are IDLE and LOCKED.
  - IDLE→LOCKED when `data_req_o`=1 and `data_gnt_i`=0; the selected index is stored in `lock_idx_q`.
  - In LOCKED, selection is forced to `lock_idx_q`; other ports cannot preempt.
  - LOCKED→IDLE on `data_gnt_i`=1.
  - A locked port that drops req violates protocol; the arbiter flags it with a simulation assertion only.
- **Muxing.**
  - Request outputs carry the selected port's fields.
  - `data_req_o` = OR of selected req AND NOT full.
  - When no port requests, outputs are zero.
- **Grant.**
  - `data_gnt_o[sel]` = `data_gnt_i` AND `data_req_o`.
  - All other grants are 0.
- **ID queue.**
  - Push the selected index when `data_req_o` AND `data_gnt_i`.
  - Pop on `data_rvalid_i`.
  - `data_rvalid_o[head]` = `data_rvalid_i`.
  - `data_rdata_o[p]` = `data_rdata_i` for all p; consumers qualify with rvalid.
- **Boundary conditions.**
  - **Full:** occupancy = `MAX_OUTSTANDING` forces `data_req_o`=0, even if a pop occurs in the same cycle. One bubble is accepted.
  - **Empty:** an rvalid with an empty queue is dropped and no port sees rvalid. A simulation assertion fires.
  - **Simultaneous push and pop, not full:** occupancy unchanged; pointers both advance, wrapping at `MAX_OUTSTANDING`.
  - **Same-cycle grant and response:** a response to the head and a new grant in the same cycle are legal. The head is popped before the new entry becomes visible.
  - **Reset mid-operation:** queue emptied, `rr_q`=0, state IDLE. Any in-flight memory responses are the memory's responsibility.

## Timing
- All reset values are 0: every output, `rr_q`, queue pointers, occupancy, and state.
- **Grant path:** combinational, `data_gnt_i`→`data_gnt_o` with zero latency.
- **Request path:** combinational, `data_req_i`→`data_req_o` with zero latency.
- **Response path:** combinational, `data_rvalid_i`→`data_rvalid_o` via the registered head index.
- **Registered state:** `rr_q`, lock state, queue contents and pointers, and occupancy, all updated on the clock edge after the triggering event.
- **No path** from `data_rvalid_i` to `data_req_o`.

## Structure
- `mem_req_arbiter_pkg`:
  - `lock_state_e` (IDLE, LOCKED).
  - Helper `port_idx_t` width function, $clog2(NR_PORTS) with minimum 1.
- Sub-module `mem_id_fifo`:
  - Parametrised width/depth circular FIFO with push, pop, head, full, empty and count.
  - Asynchronous active-low reset, no fall-through.
- Top level holds the arbiter, lock state machine, and muxes.

## Test plan
- **Round-robin fairness:** ports 0,1,2 request continuously with `data_gnt_i`=1 and immediate rvalid → grants cycle 0,1,2,0,1,2; `outstanding_o` never exceeds 1.
- **Lock under stall:** port 1 requests with `data_gnt_i`=0 for 3 cycles, and port 0 raises req in cycle 2 → `address_o` stays port 1's address; gnt goes to port 1 when `data_gnt_i`=1, then port 2 or 0 per `rr_q`.
- **Full:** `MAX_OUTSTANDING`=4, 4 grants with no rvalid → `outstanding_o`=4 and `data_req_o`=0 while ports request. One rvalid → the next cycle `data_req_o`=1 again.
- **In-order routing:** grants to ports 2,0,2 are answered by rdata 0xA,0xB,0xC → port 2 gets 0xA, port 0 gets 0xB, port 2 gets 0xC.
- **Simultaneous push/pop:** at occupancy 2, grant and rvalid in the same cycle → occupancy stays 2; queue pointers wrap correctly after 10 iterations.
- **Reset mid-flight:** 3 outstanding, then `rst_ni` pulsed low asynchronously → all outputs 0, `outstanding_o`=0, next grant goes to port 0.
